// File: rtl/blk_read_arbiter_pkg.sv
// Shared types and defaults for the block-read arbiter: FSM encoding, default
// parameter values and a width helper that never returns zero.
package blk_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_t;

  localparam int DEF_NREQ        = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_GUARD_CYC   = 1;
  localparam int DEF_MAX_HOLD    = 64;

  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/blk_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester strictly after
// 'last', wrapping, found by masking a doubled copy of the eligible vector.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         elig,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic                    any,
  output logic [$clog2(NREQ)-1:0] pick
);

  localparam int IDW = $clog2(NREQ);

  logic [2*NREQ-1:0] w_dbl;
  logic [2*NREQ-1:0] w_masked;

  assign w_dbl = {elig, elig};
  assign any   = |elig;

  // Bits at or below 'last' in the lower copy are masked; the upper copy supplies the wrap.
  always_comb begin
    w_masked = '0;
    for (int i = 0; i < 2 * NREQ; i++) begin
      w_masked[i] = w_dbl[i] && (i > int'(last));
    end
  end

  always_comb begin
    pick = '0;
    for (int i = 2 * NREQ - 1; i >= 0; i--) begin
      if (w_masked[i]) begin
        pick = (i >= NREQ) ? IDW'(i - NREQ) : IDW'(i);
      end
    end
  end

endmodule

// File: rtl/blk_read_arbiter.sv
// Round-robin arbiter for the shared block-read port: synchronised requests,
// hold-time watchdog with per-requester lockout, and a guard gap between owners.
module blk_read_arbiter
  import blk_arb_pkg::*;
#(
  parameter int NREQ        = DEF_NREQ,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int GUARD_CYC   = DEF_GUARD_CYC,
  parameter int MAX_HOLD    = DEF_MAX_HOLD
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    timeout,
  output arb_state_t              dbg_state
);

  // Handshake: four-phase req/gnt. A requester raises req and holds it; gnt
  // rises when it owns the port; the requester drops req to release and gnt
  // follows low. A new request must not be raised before gnt has fallen.

  localparam int IDW = $clog2(NREQ);
  localparam int HW  = clog2_min1(MAX_HOLD + 1);
  localparam int GW  = clog2_min1(GUARD_CYC + 1);
  localparam arb_state_t ST_RELEASE = (GUARD_CYC > 0) ? ST_GUARD : ST_IDLE;

  logic [NREQ-1:0] r_sync [SYNC_STAGES];
  logic [NREQ-1:0] r_lockout;
  logic [NREQ-1:0] r_gnt;
  logic            r_busy;
  logic            r_timeout;
  logic [IDW-1:0]  r_owner;
  logic [IDW-1:0]  r_last;
  logic [HW-1:0]   r_hold;
  logic [GW-1:0]   r_guard;
  arb_state_t      r_state;

  logic [NREQ-1:0] w_sreq;
  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_pick_oh;
  logic [NREQ-1:0] w_owner_oh;
  logic            w_any;
  logic [IDW-1:0]  w_pick;
  logic            w_owner_req;
  logic            w_watchdog;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= req;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sreq      = r_sync[SYNC_STAGES-1];
  assign w_elig      = w_sreq & ~r_lockout;
  assign w_pick_oh   = NREQ'(1) << w_pick;
  assign w_owner_oh  = NREQ'(1) << r_owner;
  assign w_owner_req = w_sreq[r_owner];
  assign w_watchdog  = (MAX_HOLD != 0) && (int'(r_hold) == MAX_HOLD - 1);

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .elig (w_elig),
    .last (r_last),
    .any  (w_any),
    .pick (w_pick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_owner   <= '0;
      r_last    <= IDW'(NREQ - 1);
      r_timeout <= 1'b0;
      r_lockout <= '0;
      r_hold    <= '0;
      r_guard   <= '0;
    end else begin
      r_timeout <= 1'b0;
      // A lockout bit survives only while its synchronised request stays high.
      r_lockout <= r_lockout & w_sreq;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_pick_oh;
            r_owner <= w_pick;
            r_last  <= w_pick;
            r_busy  <= 1'b1;
            r_hold  <= '0;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!w_owner_req) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_guard <= '0;
            r_state <= ST_RELEASE;
          end else if (w_watchdog) begin
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_guard   <= '0;
            r_timeout <= 1'b1;
            r_lockout <= (r_lockout & w_sreq) | w_owner_oh;
            r_state   <= ST_RELEASE;
          end else if (r_hold != '1) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        ST_GUARD: begin
          if (int'(r_guard) == GUARD_CYC - 1) begin
            r_state <= ST_IDLE;
          end else begin
            r_guard <= r_guard + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign busy      = r_busy;
  assign owner     = r_owner;
  assign timeout   = r_timeout;
  assign dbg_state = r_state;

endmodule
